// File: rtl/pitch_pkg.sv
// Shared types and helpers for the pitch-to-height tracker.
// Width-agnostic helpers take their parameters as arguments so every instance can reuse them.
package pitch_pkg;

    typedef enum logic [1:0] {FILL, WAIT, UPDATE} state_t;

    // Height for a peak bin: lower bins sit higher on screen, clamped to the output range.
    function automatic int unsigned bin_to_height(input int unsigned idx,
                                                  input int unsigned bin_hi,
                                                  input int unsigned h_base,
                                                  input int unsigned h_step,
                                                  input int unsigned h_max);
        longint unsigned h;
        h = 64'(h_base) + 64'(h_step) * 64'(bin_hi - idx);
        if (h > 64'(h_max)) h = 64'(h_max);
        return 32'(h);
    endfunction

    // Positive fixed-point FFT word: top (smp_w/2-1) sample bits placed just under a zero sign bit.
    function automatic int unsigned pack_sample(input int unsigned smp,
                                                input int unsigned sample_w,
                                                input int unsigned smp_w);
        int unsigned keep;
        keep = smp_w / 2 - 1;
        return (smp >> (sample_w - keep)) << (smp_w / 2);
    endfunction

endpackage

// File: rtl/height_avg.sv
// Moving average of pushed heights over a 2^AVG_LOG2-deep history ring.
// Result and valid appear the cycle after push, computed from the updated running sum.
module height_avg #(
    parameter int HEIGHT_W = 10,
    parameter int AVG_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                push,
    input  logic [HEIGHT_W-1:0] value,
    output logic [HEIGHT_W-1:0] height,
    output logic                height_valid
);
    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = HEIGHT_W + AVG_LOG2;
    localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int HIST_N = 1 << PTR_W;

    logic [HEIGHT_W-1:0] hist [HIST_N];
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_nxt;
    logic [PTR_W-1:0]    ptr;

    // ptr always points at the oldest entry, which the new value replaces.
    assign sum_nxt = sum - SUM_W'(hist[ptr]) + SUM_W'(value);

    always_ff @(posedge clk) begin
        if (reset) begin
            sum          <= '0;
            ptr          <= '0;
            height       <= '0;
            height_valid <= 1'b0;
            for (int i = 0; i < HIST_N; i++) hist[i] <= '0;
        end else begin
            height_valid <= push;
            if (push) begin
                sum       <= sum_nxt;
                hist[ptr] <= value;
                ptr       <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
                height    <= sum_nxt[SUM_W-1:AVG_LOG2];
            end
        end
    end

endmodule

// File: rtl/pitch_tracker.sv
// Mic decimator and frame builder for the FFT core, peak-bin scan with silence gating,
// and bin-to-height mapping fed into a moving average.
module pitch_tracker
    import pitch_pkg::*;
#(
    parameter int SAMPLE_W    = 12,
    parameter int FRAME_LEN   = 64,
    parameter int SMP_W       = 16,
    parameter int MAG_W       = 32,
    parameter int DECIM       = 50000,
    parameter int BIN_LO      = 1,
    parameter int BIN_HI      = 63,
    parameter int MAG_THRESH  = 1024,
    parameter int SILENT_MODE = 0,
    parameter int H_SILENT    = 50,
    parameter int H_BASE      = 16,
    parameter int H_STEP      = 5,
    parameter int HEIGHT_W    = 10,
    parameter int AVG_LOG2    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [SAMPLE_W-1:0]          smp_in,
    output logic [FRAME_LEN*SMP_W-1:0]   frame_out,
    output logic                         fft_start,
    input  logic                         bin_valid,
    input  logic [$clog2(FRAME_LEN)-1:0] bin_idx,
    input  logic [MAG_W-1:0]             bin_mag,
    input  logic                         bin_last,
    output logic [HEIGHT_W-1:0]          height,
    output logic                         height_valid,
    output logic                         silent,
    output logic                         overrun
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam int TCK_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [TCK_W-1:0]           tick_cnt;
    logic                       tick;
    logic [IDX_W-1:0]           fill_cnt;
    logic                       frame_full;
    logic [SMP_W-1:0]           smp_word;
    logic [FRAME_LEN*SMP_W-1:0] shift_reg;
    logic [FRAME_LEN*SMP_W-1:0] shift_nxt;
    state_t                     state, state_nxt;
    logic [MAG_W-1:0]           best;
    logic [IDX_W-1:0]           peak_idx;
    logic                       seen;
    logic                       beat;
    logic                       frame_silent;
    logic                       push;
    logic [HEIGHT_W-1:0]        h_calc;
    logic [HEIGHT_W-1:0]        push_val;

    assign tick       = (tick_cnt == TCK_W'(DECIM - 1));
    assign smp_word   = SMP_W'(pack_sample(32'(smp_in), SAMPLE_W, SMP_W));
    assign shift_nxt  = {shift_reg[(FRAME_LEN-1)*SMP_W-1:0], smp_word};
    assign frame_full = tick && (fill_cnt == IDX_W'(FRAME_LEN - 1));
    assign h_calc     = HEIGHT_W'(bin_to_height(32'(peak_idx), BIN_HI, H_BASE, H_STEP,
                                                (1 << HEIGHT_W) - 1));

    always_comb begin
        state_nxt    = state;
        beat         = 1'b0;
        push         = 1'b0;
        frame_silent = !seen || (best < MAG_W'(MAG_THRESH));
        push_val     = frame_silent ? HEIGHT_W'(H_SILENT) : h_calc;
        case (state)
            FILL: begin
                if (frame_full) state_nxt = WAIT;
            end
            WAIT: begin
                beat = bin_valid && (bin_idx >= IDX_W'(BIN_LO)) && (bin_idx <= IDX_W'(BIN_HI));
                if (bin_valid && bin_last) state_nxt = UPDATE;
            end
            UPDATE: begin
                push      = !frame_silent || (SILENT_MODE != 0);
                state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            tick_cnt  <= '0;
            fill_cnt  <= '0;
            shift_reg <= '0;
            frame_out <= '0;
            fft_start <= 1'b0;
            best      <= '0;
            peak_idx  <= '0;
            seen      <= 1'b0;
            silent    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            fft_start <= 1'b0;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            // fill_cnt wraps to 0 on its own when a frame completes (FRAME_LEN is a power of 2).
            if (tick) begin
                shift_reg <= shift_nxt;
                fill_cnt  <= fill_cnt + 1'b1;
            end
            if (frame_full) begin
                if (state == FILL) begin
                    frame_out <= shift_nxt;
                    fft_start <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (beat) begin
                seen <= 1'b1;
                if (bin_mag > best) begin
                    best     <= bin_mag;
                    peak_idx <= bin_idx;
                end
            end
            if (state == UPDATE) begin
                silent   <= frame_silent;
                best     <= '0;
                peak_idx <= '0;
                seen     <= 1'b0;
            end
        end
    end

    height_avg #(
        .HEIGHT_W (HEIGHT_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_avg (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .value        (push_val),
        .height       (height),
        .height_valid (height_valid)
    );

endmodule
